// File: rtl/matmul_stream_unit_if.sv
// Streaming port bundle for matmul_stream_unit: operation launch, A/B beat input and C row output.
// The unit itself connects through the slave modport.
interface matmul_stream_unit_if #(
    parameter int SIZE       = 8,
    parameter int DWIDTH     = 32,
    parameter int KW         = 5,
    parameter int REGIDWIDTH = 8
);
    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                   start;
    logic                   acc_mode;
    logic [KW-1:0]          k_len;
    logic [SIZE-1:0]        row_mask;
    logic [SIZE-1:0]        col_mask;
    logic [REGIDWIDTH-1:0]  in_dst;
    logic                   in_dst_we;
    logic [SIZE-1:0]        vmask;
    logic                   in_valid;
    logic                   in_ready;
    logic [SIZE*DWIDTH-1:0] a_col;
    logic [SIZE*DWIDTH-1:0] b_row;
    logic                   out_valid;
    logic                   out_ready;
    logic [SIZE*DWIDTH-1:0] c_row;
    logic [RW-1:0]          out_row_idx;
    logic [REGIDWIDTH-1:0]  out_dst;
    logic                   out_dst_we;
    logic [SIZE-1:0]        out_dst_mask;
    logic                   stall;
    logic                   done;

    modport master (
        output start, acc_mode, k_len, row_mask, col_mask, in_dst, in_dst_we, vmask,
               in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, c_row, out_row_idx, out_dst, out_dst_we, out_dst_mask,
               stall, done
    );

    modport slave (
        input  start, acc_mode, k_len, row_mask, col_mask, in_dst, in_dst_we, vmask,
               in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, c_row, out_row_idx, out_dst, out_dst_we, out_dst_mask,
               stall, done
    );
endinterface

// File: rtl/matmul_stream_unit.sv
// Output-stationary SIZE x SIZE outer-product matmul: A columns and B rows stream in per beat,
// then the C tile drains one masked row per beat toward vector writeback.
module matmul_stream_unit #(
    parameter int SIZE       = 8,
    parameter int DWIDTH     = 32,
    parameter int MAX_K      = 16,
    parameter int KW         = 5,
    parameter int REGIDWIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    matmul_stream_unit_if.slave bus
);
    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                  state;
    logic [DWIDTH-1:0]       acc [SIZE][SIZE];
    logic [KW-1:0]           k_lat;
    logic [KW-1:0]           k_cnt;
    logic [KW-1:0]           k_clamped;
    logic [RW-1:0]           row_idx;
    logic [SIZE-1:0]         row_mask_q;
    logic [SIZE-1:0]         col_mask_q;
    logic [SIZE-1:0]         vmask_q;
    logic [REGIDWIDTH-1:0]   dst_q;
    logic                    dst_we_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    stall_q;
    logic                    done_q;
    logic [SIZE*DWIDTH-1:0]  c_row_int;

    assign k_clamped = (bus.k_len > KW'(MAX_K)) ? KW'(MAX_K) : bus.k_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            k_lat       <= '0;
            k_cnt       <= '0;
            row_idx     <= '0;
            row_mask_q  <= '0;
            col_mask_q  <= '0;
            vmask_q     <= '0;
            dst_q       <= '0;
            dst_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    acc[i][j] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k_lat      <= k_clamped;
                        k_cnt      <= '0;
                        row_idx    <= '0;
                        row_mask_q <= bus.row_mask;
                        col_mask_q <= bus.col_mask;
                        vmask_q    <= bus.vmask;
                        dst_q      <= bus.in_dst;
                        dst_we_q   <= bus.in_dst_we;
                        stall_q    <= 1'b1;
                        if (!bus.acc_mode)
                            for (int i = 0; i < SIZE; i++)
                                for (int j = 0; j < SIZE; j++)
                                    acc[i][j] <= '0;
                        // A zero-depth start skips LOAD and just reads C out.
                        if (k_clamped == '0) begin
                            state       <= DRAIN;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        for (int i = 0; i < SIZE; i++)
                            for (int j = 0; j < SIZE; j++)
                                acc[i][j] <= acc[i][j] + bus.a_col[i*DWIDTH +: DWIDTH] * bus.b_row[j*DWIDTH +: DWIDTH];
                        if (k_cnt == k_lat - 1'b1) begin
                            k_cnt       <= '0;
                            state       <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (row_idx == RW'(SIZE - 1)) begin
                            row_idx     <= '0;
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            stall_q     <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    stall_q     <= 1'b0;
                end
            endcase
        end
    end

    // Gating on out_valid keeps c_row at zero outside DRAIN, including straight after reset.
    always_comb begin
        c_row_int = '0;
        if (out_valid_q && row_mask_q[row_idx])
            for (int j = 0; j < SIZE; j++)
                if (col_mask_q[j])
                    c_row_int[j*DWIDTH +: DWIDTH] = acc[row_idx][j];
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.c_row        = c_row_int;
    assign bus.out_row_idx  = row_idx;
    assign bus.out_dst      = dst_q + REGIDWIDTH'(row_idx);
    assign bus.out_dst_we   = dst_we_q & out_valid_q;
    assign bus.out_dst_mask = vmask_q;
    assign bus.stall        = stall_q;
    assign bus.done         = done_q;
endmodule
